// File: rtl/user_clk_sel_ctrl_if.sv
// Request handshake between a clock-switch requester and user_clk_sel_ctrl.
// master = requester (drives valid/sel), slave = controller (drives ready).
interface user_clk_sel_ctrl_if;
  logic valid;
  logic sel;
  logic ready;

  modport master (output valid, output sel, input ready);
  modport slave  (input valid, input sel, output ready);
endinterface

// File: rtl/user_clk_sel_ctrl.sv
// user_clk_sel_ctrl: drives the select of a glitchless clock mux.
// A request changes the selection and is followed by a SETTLE window
// (mux handover) and a DWELL window. No new request is accepted in either window.
// switch_done pulses in the last SETTLE cycle; switch_count counts completed changes.
// Optional feature: macro CLK_SEL_FAILOVER_EN adds forced switching away
// from a dead clock (clk1_alive/clk2_alive inputs, fail_event output).
module user_clk_sel_ctrl #(
  parameter int          SETTLE_CYCLES    = 16,
  parameter int          MIN_DWELL_CYCLES = 64,
  parameter logic        RESET_SEL        = 1'b0,
  parameter int          CNT_WIDTH        = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  user_clk_sel_ctrl_if.slave   req,
  output logic                 selection,
  output logic                 busy,
  output logic                 switch_done,
  output logic [CNT_WIDTH-1:0] switch_count
`ifdef CLK_SEL_FAILOVER_EN
  ,
  input  logic                 clk1_alive,
  input  logic                 clk2_alive,
  output logic                 fail_event
`endif
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > MIN_DWELL_CYCLES) ? SETTLE_CYCLES : MIN_DWELL_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES + 1);

  // Timers count down to zero; the state lasts (load + 1) cycles.
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] DWELL_LOAD  = TW'(MIN_DWELL_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
  // With a one-cycle settle, the first SETTLE cycle is also the last one.
  localparam bit            SETTLE_ONE  = (SETTLE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DWELL  = 2'd2
  } state_t;

  state_t               state_reg;
  logic [TW-1:0]        timer_reg;
  logic                 selection_reg;
  logic                 busy_reg;
  logic                 switch_done_reg;
  logic [CNT_WIDTH-1:0] switch_count_reg;
  logic                 fail_event_reg;

  logic fail_trig;
  logic accept;
  logic start_switch;
  logic start_sel;

`ifdef CLK_SEL_FAILOVER_EN
  // Forced switch when the selected clock is dead and the other one is alive.
  always_comb begin
    fail_trig = 1'b0;
    if (state_reg == IDLE || state_reg == DWELL) begin
      if (selection_reg)
        fail_trig = !clk2_alive && clk1_alive;
      else
        fail_trig = !clk1_alive && clk2_alive;
    end
  end
`else
  assign fail_trig = 1'b0;
`endif

  // Ready is combinational so a request can be taken in the first IDLE cycle;
  // a pending failover masks it so the forced switch always wins.
  assign req.ready = (state_reg == IDLE) && !fail_trig;
  assign accept    = req.valid && req.ready;

  // A sequence starts on a failover or on an accepted request that changes the selection.
  always_comb begin
    start_switch = fail_trig || (accept && (req.sel != selection_reg));
    start_sel    = fail_trig ? !selection_reg : req.sel;
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_reg        <= IDLE;
      timer_reg        <= '0;
      selection_reg    <= RESET_SEL;
      busy_reg         <= 1'b0;
      switch_done_reg  <= 1'b0;
      switch_count_reg <= '0;
      fail_event_reg   <= 1'b0;
    end else begin
      switch_done_reg <= 1'b0;
      fail_event_reg  <= 1'b0;
      if (start_switch) begin
        state_reg      <= SETTLE;
        timer_reg      <= SETTLE_LOAD;
        selection_reg  <= start_sel;
        busy_reg       <= 1'b1;
        fail_event_reg <= fail_trig;
        if (SETTLE_ONE) begin
          switch_done_reg  <= 1'b1;
          switch_count_reg <= switch_count_reg + 1'b1;
        end
      end else begin
        case (state_reg)
          SETTLE: begin
            if (timer_reg == '0) begin
              state_reg <= DWELL;
              timer_reg <= DWELL_LOAD;
            end else begin
              timer_reg <= timer_reg - 1'b1;
              // Entering the final SETTLE cycle: pulse done there.
              if (timer_reg == TIMER_ONE) begin
                switch_done_reg  <= 1'b1;
                switch_count_reg <= switch_count_reg + 1'b1;
              end
            end
          end
          DWELL: begin
            if (timer_reg == '0) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end else begin
              timer_reg <= timer_reg - 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
          end
        endcase
      end
    end
  end

  assign selection    = selection_reg;
  assign busy         = busy_reg;
  assign switch_done  = switch_done_reg;
  assign switch_count = switch_count_reg;

`ifdef CLK_SEL_FAILOVER_EN
  assign fail_event = fail_event_reg;
`else
  // Without failover the pulse register is held at zero and unused.
  logic unused_fail;
  assign unused_fail = fail_event_reg;
`endif

endmodule

// File: tb/tb_user_clk_sel_ctrl.sv
// Scoreboard bench for user_clk_sel_ctrl (default parameters).
// Stimulus pushes the expected switch_done (selection, count, cycle) into a queue;
// a monitor pops and compares on every switch_done pulse.
module tb_user_clk_sel_ctrl;

  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          selection;
  logic          busy;
  logic          switch_done;
  logic [CW-1:0] switch_count;
`ifdef CLK_SEL_FAILOVER_EN
  logic          clk1_alive;
  logic          clk2_alive;
  logic          fail_event;
`endif

  user_clk_sel_ctrl_if bus ();

  user_clk_sel_ctrl dut (
    .aclk         (aclk),
    .areset       (areset),
    .req          (bus.slave),
    .selection    (selection),
    .busy         (busy),
    .switch_done  (switch_done),
    .switch_count (switch_count)
`ifdef CLK_SEL_FAILOVER_EN
    ,
    .clk1_alive   (clk1_alive),
    .clk2_alive   (clk2_alive),
    .fail_event   (fail_event)
`endif
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic          sel;
    logic [CW-1:0] cnt;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];

  int   checks = 0;
  int   errors = 0;
  logic model_sel = 1'b0;
  logic [CW-1:0] model_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every switch_done pulse must match the oldest expected completion.
  always @(negedge aclk) begin
    if (switch_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_switch_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_selection", {31'd0, selection}, {31'd0, e.sel});
        check("done_count", {16'd0, switch_count}, {16'd0, e.cnt});
        check("done_cycle", cyc, e.cyc);
        $display("done  cycle=%0d sel=%0d count=%0d", cyc, selection, switch_count);
      end
    end
  end

  // Present a request and wait (bounded) for acceptance. Returns at the
  // negedge after the accept edge with valid still asserted; acc is the
  // cycle in which the request was accepted.
  task automatic issue(input logic s, output int acc);
    bit ok;
    ok = 1'b0;
    bus.valid = 1'b1;
    bus.sel   = s;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.ready === 1'b1) begin
        ok  = 1'b1;
        acc = cyc;
        break;
      end
      @(negedge aclk);
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    if (ok && s != model_sel) begin
      exp_t e;
      model_sel = s;
      model_cnt = model_cnt + 1'b1;
      e.sel = s;
      e.cnt = model_cnt;
      e.cyc = acc + 16;
      exp_q.push_back(e);
    end
    $display("req   cycle=%0d sel=%0d accepted=%0d", acc, s, ok);
    @(negedge aclk);
  endtask

  // Wait (bounded) for req_ready; returns the cycle it was seen.
  task automatic wait_ready(output int rc);
    rc = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.ready === 1'b1) begin
        rc = cyc;
        break;
      end
      @(negedge aclk);
    end
    if (rc < 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int b;
    int r;
    areset    = 1'b1;
    bus.valid = 1'b0;
    bus.sel   = 1'b0;
`ifdef CLK_SEL_FAILOVER_EN
    clk1_alive = 1'b1;
    clk2_alive = 1'b1;
`endif

    // Reset held 5 cycles: values stay at reset state.
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("rst_selection", {31'd0, selection}, 32'd0);
      check("rst_ready", {31'd0, bus.ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_count", {16'd0, switch_count}, 32'd0);
    end
    areset = 1'b0;
    @(negedge aclk);

    // Same-selection request: accepted immediately, nothing changes.
    issue(1'b0, a);
    bus.valid = 1'b0;
    check("same_sel_selection", {31'd0, selection}, 32'd0);
    check("same_sel_busy", {31'd0, busy}, 32'd0);
    check("same_sel_ready", {31'd0, bus.ready}, 32'd1);
    check("same_sel_count", {16'd0, switch_count}, 32'd0);

    // Switch to 1: selection changes after accept, ready returns at T+81.
    issue(1'b1, a);
    bus.valid = 1'b0;
    check("sw1_selection", {31'd0, selection}, 32'd1);
    check("sw1_busy", {31'd0, busy}, 32'd1);
    check("sw1_ready_low", {31'd0, bus.ready}, 32'd0);
    wait_ready(r);
    check("sw1_ready_cycle", r, a + 81);
    check("sw1_count", {16'd0, switch_count}, 32'd1);
    check("sw1_busy_end", {31'd0, busy}, 32'd0);

    // Switch to 0, then hold valid with req_sel=1 across SETTLE/DWELL:
    // the held request is taken on the first IDLE cycle.
    issue(1'b0, a);
    bus.sel = 1'b1;
    @(negedge aclk);
    check("held_sel_not_resampled", {31'd0, selection}, 32'd0);
    issue(1'b1, b);
    bus.valid = 1'b0;
    check("held_accept_cycle", b, a + 81);
    check("held_selection", {31'd0, selection}, 32'd1);
    wait_ready(r);
    check("held_count", {16'd0, switch_count}, 32'd3);

    // Complete switch back to 0.
    issue(1'b0, a);
    bus.valid = 1'b0;
    wait_ready(r);
    check("sw0_ready_cycle", r, a + 81);
    check("sw0_count", {16'd0, switch_count}, 32'd4);

    // Reset 5 cycles into SETTLE aborts the sequence.
    issue(1'b1, a);
    bus.valid = 1'b0;
    void'(exp_q.pop_back());
    while (cyc < a + 5) @(negedge aclk);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    model_sel = 1'b0;
    model_cnt = '0;
    check("abort_selection", {31'd0, selection}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ready", {31'd0, bus.ready}, 32'd1);
    check("abort_count", {16'd0, switch_count}, 32'd0);
    check("abort_done", {31'd0, switch_done}, 32'd0);
    repeat (20) @(negedge aclk);

    // Counting restarts after reset.
    issue(1'b1, a);
    bus.valid = 1'b0;
    wait_ready(r);
    check("post_rst_ready_cycle", r, a + 81);
    check("post_rst_count", {16'd0, switch_count}, 32'd1);

`ifdef CLK_SEL_FAILOVER_EN
    issue(1'b0, a);
    bus.valid = 1'b0;
    wait_ready(r);
    // clk1 dies while selected, with a simultaneous same-clock request.
    clk1_alive = 1'b0;
    clk2_alive = 1'b1;
    bus.valid  = 1'b1;
    bus.sel    = 1'b0;
    #1;
    check("fo_ready_masked", {31'd0, bus.ready}, 32'd0);
    begin
      exp_t e;
      model_sel = 1'b1;
      model_cnt = model_cnt + 1'b1;
      e.sel = 1'b1;
      e.cnt = model_cnt;
      e.cyc = cyc + 16;
      exp_q.push_back(e);
    end
    @(negedge aclk);
    bus.valid = 1'b0;
    $display("fail  cycle=%0d fail_event=%0d sel=%0d", cyc, fail_event, selection);
    check("fo_fail_event", {31'd0, fail_event}, 32'd1);
    check("fo_selection", {31'd0, selection}, 32'd1);
    check("fo_busy", {31'd0, busy}, 32'd1);
    @(negedge aclk);
    check("fo_fail_event_pulse", {31'd0, fail_event}, 32'd0);
    wait_ready(r);
    clk1_alive = 1'b1;
`endif

    repeat (5) @(negedge aclk);
    check("pending_done", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
